// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : shared definitions for the multi-cycle accumulator ALU (alu_seq).
//   - Opcode constants (3-bit encoding used by the control unit).
//   - FSM state encoding (IDLE, EXEC, RUN, FIN).
//   - is_iter(): tells whether an opcode takes the one-bit-per-clock path.
// Optional build macro: ALU_FAST_MUL_EN (MUL becomes single-cycle).
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_MOD  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_NOP7 = 3'd7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_FIN  = 2'd3;

  // Opcodes that iterate for WIDTH clocks in RUN.
  function automatic logic is_iter(input logic [2:0] op);
`ifdef ALU_FAST_MUL_EN
    return (op == OP_DIV) || (op == OP_MOD);
`else
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if : request/response bundle between the control unit and alu_seq.
//   master (control unit): drives start, alu_op, in1, in2;
//                          observes busy, done, alu_out, z, dz.
//   slave  (ALU)         : the reverse.
// ---------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 3
);
  logic             start;
  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_out;
  logic             z;
  logic             dz;

  modport master (
    output start, alu_op, in1, in2,
    input  busy, done, alu_out, z, dz
  );

  modport slave (
    input  start, alu_op, in1, in2,
    output busy, done, alu_out, z, dz
  );
endinterface

// File: rtl/alu_divider.sv
// ---------------------------------------------------------------------------
// alu_divider : WIDTH-bit unsigned restoring divider, one quotient bit/clock.
//   i_init     : load dividend, clear partial remainder.
//   i_step     : perform one iteration.
//   i_dividend, i_divisor : latched operands from alu_seq.
//   o_quo, o_rem : quotient/remainder AFTER the current iteration, so they
//                  hold the final result during the last step cycle.
// A zero divisor always "fits", giving an all-ones quotient and a
// remainder equal to the dividend with no special casing.
// ---------------------------------------------------------------------------
module alu_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_init,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_fit;

  // Shift next dividend bit into the partial remainder and trial-subtract.
  // The true difference is below the divisor, so WIDTH bits suffice.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_fit   = (w_shift >= {1'b0, i_divisor});
  assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;
  assign o_quo   = {r_quo[WIDTH-2:0], w_fit};
  assign o_rem   = w_fit ? w_diff : w_shift[WIDTH-1:0];

  // Quotient/remainder registers: loaded on init, advanced on each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo <= {WIDTH{1'b0}};
      r_rem <= {WIDTH{1'b0}};
    end else if (i_init) begin
      r_quo <= i_dividend;
      r_rem <= {WIDTH{1'b0}};
    end else if (i_step) begin
      r_quo <= o_quo;
      r_rem <= o_rem;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : multi-cycle accumulator ALU with start/busy/done handshake.
//   clk   : system clock (rising edge)
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_if.slave -- start, alu_op, in1 (AC), in2 (register)
//           in; busy, done, alu_out, z, dz out (all registered).
// Ops: 1 ADD, 2 XOR, 3 MUL, 4 DIV, 5 MOD, 6 SHL1, 0/7 NOP.
// Build macro ALU_FAST_MUL_EN: MUL uses a combinational multiplier and the
// two-cycle path; otherwise MUL is shift-add over WIDTH clocks.
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OP_W  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OP_W-1:0]  r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_alu_out;
  logic             r_busy;
  logic             r_done;
  logic             r_z;
  logic             r_dz;
  logic [2:0]       w_op;
  logic             w_iter;
  logic             w_last;
  logic [WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_result;

  assign w_op   = 3'(r_op);
  assign w_iter = is_iter(w_op);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Next-state logic: only IDLE listens to start, so starts are never queued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_EXEC;
        else           w_state_nxt = ST_IDLE;
      end
      ST_EXEC: begin
        if (w_iter) w_state_nxt = ST_RUN;
        else        w_state_nxt = ST_FIN;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_FIN;
        else        w_state_nxt = ST_RUN;
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef ALU_FAST_MUL_EN
  assign w_prod = r_a * r_b;
`else
  logic [WIDTH-1:0] r_mul_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;

  // Accumulator after the current iteration; equals the product in the
  // final RUN cycle, which is when the result is captured.
  assign w_prod = r_mplier[0] ? (r_mul_acc + r_mcand) : r_mul_acc;

  // Shift-add multiplier: multiplier LSB-first, multiplicand shifts left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_acc <= {WIDTH{1'b0}};
      r_mcand   <= {WIDTH{1'b0}};
      r_mplier  <= {WIDTH{1'b0}};
    end else if (r_state == ST_EXEC) begin
      r_mul_acc <= {WIDTH{1'b0}};
      r_mcand   <= r_a;
      r_mplier  <= r_b;
    end else if (r_state == ST_RUN) begin
      r_mul_acc <= w_prod;
      r_mcand   <= {r_mcand[WIDTH-2:0], 1'b0};
      r_mplier  <= {1'b0, r_mplier[WIDTH-1:1]};
    end
  end
`endif

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_init     (r_state == ST_EXEC),
    .i_step     (r_state == ST_RUN),
    .i_dividend (r_a),
    .i_divisor  (r_b),
    .o_quo      (w_quo),
    .o_rem      (w_rem)
  );

  // Result select; NOP opcodes keep the previous result.
  always_comb begin
    w_result = r_alu_out;
    case (w_op)
      OP_ADD:  w_result = r_a + r_b;
      OP_XOR:  w_result = r_a ^ r_b;
      OP_MUL:  w_result = w_prod;
      OP_DIV:  w_result = w_quo;
      OP_MOD:  w_result = w_rem;
      OP_SHL:  w_result = {r_a[WIDTH-2:0], 1'b0};
      default: w_result = r_alu_out;
    endcase
  end

  // FSM, operand latches, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_a       <= {WIDTH{1'b0}};
      r_b       <= {WIDTH{1'b0}};
      r_op      <= {OP_W{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_alu_out <= {WIDTH{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_z       <= 1'b1;
      r_dz      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_FIN);
      if ((r_state == ST_IDLE) && bus.start) begin
        r_a  <= bus.in1;
        r_b  <= bus.in2;
        r_op <= bus.alu_op;
      end
      if (r_state == ST_EXEC)     r_cnt <= {CW{1'b0}};
      else if (r_state == ST_RUN) r_cnt <= r_cnt + CW'(1);
      // Result and both flags are written together on entry to FIN.
      if (w_state_nxt == ST_FIN) begin
        r_alu_out <= w_result;
        r_z       <= (w_result == {WIDTH{1'b0}});
        r_dz      <= ((w_op == OP_DIV) || (w_op == OP_MOD)) && (r_b == {WIDTH{1'b0}});
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.alu_out = r_alu_out;
  assign bus.z       = r_z;
  assign bus.dz      = r_dz;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : self-checking bench for alu_seq (WIDTH=16). Expected results
// come from a plain-arithmetic model of the ALU's rules.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  // Model state: last result and divide-by-zero flag.
  logic [15:0] m_out = 16'h0000;
  logic        m_dz  = 1'b0;

  alu_seq_if #(.WIDTH(16), .OP_W(3)) bus ();

  alu_seq #(.WIDTH(16), .OP_W(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_res(input int op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] prev);
    int unsigned sa = a;
    int unsigned sb = b;
    case (op)
      1: return 16'((sa + sb) % 65536);
      2: return a ^ b;
      3: return 16'((sa * sb) % 65536);
      4: return (sb == 0) ? 16'hFFFF : 16'(sa / sb);
      5: return (sb == 0) ? a : 16'(sa % sb);
      6: return 16'((sa * 2) % 65536);
      default: return prev;
    endcase
  endfunction

  function automatic int model_lat(input int op);
    if (op == 4 || op == 5) return 18;
`ifdef ALU_FAST_MUL_EN
    if (op == 3) return 2;
`else
    if (op == 3) return 18;
`endif
    return 2;
  endfunction

  // Issue one op at the current negedge, check latency, result and flags,
  // and finish at the negedge of the cycle after done.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input bit scramble);
    logic [15:0] exp_out;
    logic        exp_dz;
    int          exp_lat;
    int          lat;
    exp_out = model_res(int'(op), a, b, m_out);
    exp_dz  = ((op == 3'd4) || (op == 3'd5)) && (b == 16'h0000);
    exp_lat = model_lat(int'(op));
    bus.start = 1'b1; bus.alu_op = op; bus.in1 = a; bus.in2 = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    if (scramble) begin
      bus.in1 = 16'($urandom); bus.in2 = 16'($urandom); bus.alu_op = 3'($urandom);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL busy_after_start op=%0d got=%b exp=1", op, bus.busy);
    end
    while (bus.done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++; $display("FAIL latency op=%0d got=%0d exp=%0d", op, lat, exp_lat);
    end
    checks++;
    if (bus.alu_out !== exp_out) begin
      failures++; $display("FAIL alu_out op=%0d a=%h b=%h got=%h exp=%h", op, a, b, bus.alu_out, exp_out);
    end
    checks++;
    if (bus.z !== (exp_out == 16'h0000)) begin
      failures++; $display("FAIL z op=%0d got=%b exp=%b", op, bus.z, (exp_out == 16'h0000));
    end
    checks++;
    if (bus.dz !== exp_dz) begin
      failures++; $display("FAIL dz op=%0d got=%b exp=%b", op, bus.dz, exp_dz);
    end
    m_out = exp_out;
    m_dz  = exp_dz;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL done_pulse op=%0d done=%b busy=%b exp=0/0", op, bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.alu_op = 3'd0; bus.in1 = 16'h0; bus.in2 = 16'h0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (bus.alu_out !== 16'h0 || bus.z !== 1'b1 || bus.dz !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got out=%h z=%b dz=%b busy=%b done=%b exp 0000/1/0/0/0",
               bus.alu_out, bus.z, bus.dz, bus.busy, bus.done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.alu_out !== 16'h0 || bus.z !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got out=%h z=%b busy=%b done=%b", bus.alu_out, bus.z, bus.busy, bus.done);
    end
    m_out = 16'h0; m_dz = 1'b0;
  endtask

  task automatic test_directed();
    run_op(3'd1, 16'd3,    16'd4,    1'b1);  // ADD with inputs scrambled later
    run_op(3'd2, 16'hA5A5, 16'hA5A5, 1'b0);  // XOR -> 0, z=1
    run_op(3'd6, 16'h8001, 16'h0000, 1'b0);  // SHL1 drops MSB
    run_op(3'd3, 16'h00FF, 16'h0101, 1'b1);  // MUL -> FFFF
    run_op(3'd3, 16'h1000, 16'h0010, 1'b0);  // MUL overflow -> 0
    run_op(3'd0, 16'h1234, 16'h5678, 1'b0);  // NOP holds 0, z=1
    run_op(3'd4, 16'd100,  16'd7,    1'b1);  // DIV -> 14
    run_op(3'd5, 16'd100,  16'd7,    1'b0);  // remainder -> 2
    run_op(3'd4, 16'h1234, 16'h0000, 1'b0);  // DIV by 0 -> FFFF, dz
    run_op(3'd7, 16'h0000, 16'h0000, 1'b0);  // NOP clears dz, holds FFFF
    run_op(3'd5, 16'hBEEF, 16'h0000, 1'b1);  // remainder by 0 -> in1, dz
    run_op(3'd1, 16'hFFFF, 16'h0001, 1'b0);  // ADD carry dropped -> 0, dz cleared
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      run_op(op, a, b, ($urandom_range(0, 1) == 1));
    end
  endtask

  // Starts during busy and in the done cycle are ignored; the start in the
  // cycle after done is accepted.
  task automatic test_back_to_back();
    logic [15:0] exp_out;
    int          lat;
    int          exp_lat;
    exp_out = model_res(3, 16'h0123, 16'h0456, m_out);
    exp_lat = model_lat(3);
    bus.start = 1'b1; bus.alu_op = 3'd3; bus.in1 = 16'h0123; bus.in2 = 16'h0456;
    @(negedge clk);
    lat = 1;
    bus.alu_op = 3'd1; bus.in1 = 16'h1111; bus.in2 = 16'h2222;  // start stays high
    while (bus.done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, exp_lat);
    end
    checks++;
    if (bus.alu_out !== exp_out) begin
      failures++; $display("FAIL b2b_result got=%h exp=%h", bus.alu_out, exp_out);
    end
    m_out = exp_out; m_dz = 1'b0;
    @(negedge clk);  // start was high through the done cycle
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL b2b_ignored busy=%b done=%b exp=0/0", bus.busy, bus.done);
    end
    run_op(3'd2, 16'h0F0F, 16'h00FF, 1'b0);  // accepted in cycle after done
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1; bus.alu_op = 3'd4; bus.in1 = 16'd500; bus.in2 = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c < 8; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.alu_out !== 16'h0 || bus.z !== 1'b1 ||
        bus.dz !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got busy=%b out=%h z=%b dz=%b done=%b exp 0/0000/1/0/0",
               bus.busy, bus.alu_out, bus.z, bus.dz, bus.done);
    end
    m_out = 16'h0; m_dz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL no_done_after_reset cycle=%0d done=%b busy=%b", c, bus.done, bus.busy);
      end
    end
    run_op(3'd4, 16'd100, 16'd7, 1'b0);
    run_op(3'd1, 16'd3,   16'd4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    run_op(3'd3, 16'hAAAA, 16'h0003, 1'b0);  // a non-zero result before the abort
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
